median3x3_stream: RTL

//  Streaming 3x3 median filter for 8-bit greyscale raster frames; removes salt-and-pepper noise ahead of face_reader.

---
 rtl/median3x3_stream.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/median3x3_stream.sv
// Streaming 3x3 median filter for raster-order greyscale frames. Border pixels pass
// through unfiltered; interior pixels take the median of their 3x3 neighbourhood.
module median3x3_stream #(
  parameter int IMG_WIDTH  = 410,
  parameter int IMG_HEIGHT = 361,
  parameter int DEPTH      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DEPTH-1:0] pixel_in,
  output logic             out_valid,
  output logic [DEPTH-1:0] pixel_out,
  output logic             frame_done
);

  localparam int XW  = $clog2(IMG_WIDTH);
  localparam int YW  = $clog2(IMG_HEIGHT);
  localparam int CW  = $clog2(IMG_WIDTH + 2);
  localparam int LAT = 3;

  typedef enum logic [1:0] {LOAD, DRAIN, FLUSH} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    prime_q;
  logic [XW-1:0]    x_q, xc_q;
  logic [YW-1:0]    y_q, yc_q;
  logic             in_ready_q;

  logic [DEPTH-1:0] lb1_q [IMG_WIDTH];
  logic [DEPTH-1:0] lb2_q [IMG_WIDTH];
  logic [DEPTH-1:0] win_q [3][3];
  logic             wv_q, wb_q, wl_q;

  logic             sa_vld_q, sa_bord_q, sa_last_q;
  logic [DEPTH-1:0] sa_ctr_q, sa_lo_q, sa_md_q, sa_hi_q;

  logic             out_valid_q, frame_done_q;
  logic [DEPTH-1:0] pixel_out_q;

  // Handshake: a pixel transfers on a rising edge where in_valid and in_ready are both
  // high; in_ready is a registered output, out_valid is a one-cycle qualifier with no
  // downstream backpressure.
  logic             step, emit;
  logic [DEPTH-1:0] step_pix;
  logic             x_last, y_last, xc_last, yc_last, border;

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign pixel_out  = pixel_out_q;
  assign frame_done = frame_done_q;

  assign step     = ((state_q == LOAD) && in_valid && in_ready_q) || (state_q == DRAIN);
  assign step_pix = (state_q == DRAIN) ? '0 : pixel_in;
  assign emit     = step && (prime_q == CW'(IMG_WIDTH + 1));
  assign x_last   = (x_q == XW'(IMG_WIDTH - 1));
  assign y_last   = (y_q == YW'(IMG_HEIGHT - 1));
  assign xc_last  = (xc_q == XW'(IMG_WIDTH - 1));
  assign yc_last  = (yc_q == YW'(IMG_HEIGHT - 1));
  assign border   = (xc_q == '0) || xc_last || (yc_q == '0) || yc_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LOAD;
      cnt_q      <= '0;
      prime_q    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      xc_q       <= '0;
      yc_q       <= '0;
      in_ready_q <= 1'b0;
    end else begin
      if (step) begin
        x_q <= x_last ? '0 : x_q + 1'b1;
        if ((state_q == LOAD) && x_last) y_q <= y_last ? '0 : y_q + 1'b1;
        if (!emit) prime_q <= prime_q + 1'b1;
      end
      if (emit) begin
        xc_q <= xc_last ? '0 : xc_q + 1'b1;
        if (xc_last) yc_q <= yc_last ? '0 : yc_q + 1'b1;
      end
      case (state_q)
        LOAD: begin
          in_ready_q <= 1'b1;
          if (step && x_last && y_last) begin
            state_q    <= DRAIN;
            in_ready_q <= 1'b0;
            cnt_q      <= '0;
          end
        end
        DRAIN: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(IMG_WIDTH)) begin
            state_q <= FLUSH;
            cnt_q   <= '0;
          end
        end
        FLUSH: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(LAT - 1)) begin
            state_q    <= LOAD;
            in_ready_q <= 1'b1;
            cnt_q      <= '0;
            prime_q    <= '0;
            x_q        <= '0;
            y_q        <= '0;
            xc_q       <= '0;
            yc_q       <= '0;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  // Line buffers hold rows y-1 and y-2; they need no reset since stale rows only
  // ever reach border centres, which bypass the median.
  always_ff @(posedge clk) begin
    if (step) begin
      lb1_q[x_q] <= step_pix;
      lb2_q[x_q] <= lb1_q[x_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= '0;
      wv_q <= 1'b0;
      wb_q <= 1'b0;
      wl_q <= 1'b0;
    end else begin
      if (step) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= lb2_q[x_q];
        win_q[1][2] <= lb1_q[x_q];
        win_q[2][2] <= step_pix;
      end
      wv_q <= emit;
      wb_q <= border;
      wl_q <= emit && xc_last && yc_last;
    end
  end

  function automatic logic [DEPTH-1:0] min2(input logic [DEPTH-1:0] a, input logic [DEPTH-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [DEPTH-1:0] max2(input logic [DEPTH-1:0] a, input logic [DEPTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [DEPTH-1:0] med3(input logic [DEPTH-1:0] a, input logic [DEPTH-1:0] b,
                                            input logic [DEPTH-1:0] c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  // Median of nine = median of (max of row minima, median of row medians, min of row maxima).
  logic [DEPTH-1:0] row_lo [3];
  logic [DEPTH-1:0] row_md [3];
  logic [DEPTH-1:0] row_hi [3];

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      row_lo[r] = min2(min2(win_q[r][0], win_q[r][1]), win_q[r][2]);
      row_md[r] = med3(win_q[r][0], win_q[r][1], win_q[r][2]);
      row_hi[r] = max2(max2(win_q[r][0], win_q[r][1]), win_q[r][2]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_vld_q  <= 1'b0;
      sa_bord_q <= 1'b0;
      sa_last_q <= 1'b0;
      sa_ctr_q  <= '0;
      sa_lo_q   <= '0;
      sa_md_q   <= '0;
      sa_hi_q   <= '0;
    end else begin
      sa_vld_q  <= wv_q;
      sa_bord_q <= wb_q;
      sa_last_q <= wl_q;
      sa_ctr_q  <= win_q[1][1];
      sa_lo_q   <= max2(max2(row_lo[0], row_lo[1]), row_lo[2]);
      sa_md_q   <= med3(row_md[0], row_md[1], row_md[2]);
      sa_hi_q   <= min2(min2(row_hi[0], row_hi[1]), row_hi[2]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      pixel_out_q  <= '0;
    end else begin
      out_valid_q  <= sa_vld_q;
      frame_done_q <= sa_vld_q && sa_last_q;
      if (sa_vld_q) pixel_out_q <= sa_bord_q ? sa_ctr_q : med3(sa_lo_q, sa_md_q, sa_hi_q);
    end
  end

endmodule
